// File: rtl/kmeans_clustering.sv
`default_nettype none
// ============================================================================
//  Module      : kmeans_clustering
//  Description : K-means assignment step for one 4-D point against three
//                centroids. Computes the squared Euclidean distance to each
//                centroid and registers the distances together with the
//                index of the nearest centroid. One point is accepted per
//                cycle; results appear after the next rising clock edge.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W  : width of every (unsigned) point and centroid coordinate
//    DIST_W  : width of each distance output
//  Ports
//    clk                        : clock, rising edge active
//    reset                      : asynchronous reset, active low
//    data_in1..data_in4         : point coordinates 1..4
//    centroid1_1..centroid1_4   : centroid 1 coordinates 1..4
//    centroid2_1..centroid2_4   : centroid 2 coordinates 1..4
//    centroid3_1..centroid3_4   : centroid 3 coordinates 1..4
//    cluster_addr               : registered nearest-centroid index
//                                 (00 = C1, 01 = C2, 10 = C3; 11 never used)
//    dist_sum1..dist_sum3       : registered saturated squared distances
// ============================================================================
module kmeans_clustering #(
    parameter int DATA_W = 16,
    parameter int DIST_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    input  logic [DATA_W-1:0] data_in4,
    input  logic [DATA_W-1:0] centroid1_1,
    input  logic [DATA_W-1:0] centroid1_2,
    input  logic [DATA_W-1:0] centroid1_3,
    input  logic [DATA_W-1:0] centroid1_4,
    input  logic [DATA_W-1:0] centroid2_1,
    input  logic [DATA_W-1:0] centroid2_2,
    input  logic [DATA_W-1:0] centroid2_3,
    input  logic [DATA_W-1:0] centroid2_4,
    input  logic [DATA_W-1:0] centroid3_1,
    input  logic [DATA_W-1:0] centroid3_2,
    input  logic [DATA_W-1:0] centroid3_3,
    input  logic [DATA_W-1:0] centroid3_4,
    output logic [1:0]        cluster_addr,
    output logic [DIST_W-1:0] dist_sum1,
    output logic [DIST_W-1:0] dist_sum2,
    output logic [DIST_W-1:0] dist_sum3
);

    localparam int SQ_W  = 2 * DATA_W;
    // The accumulator is two bits wider than the larger of a squared term
    // and the output, so four terms can never wrap before saturation.
    localparam int SUM_W = ((SQ_W > DIST_W) ? SQ_W : DIST_W) + 2;

    localparam logic [1:0] SEL_C1 = 2'b00;
    localparam logic [1:0] SEL_C2 = 2'b01;
    localparam logic [1:0] SEL_C3 = 2'b10;

    // ------------------------------------------------------------------------
    // Gather the flat ports into arrays so the datapath can be generated.
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] point [4];
    logic [DATA_W-1:0] cent  [3][4];

    always_comb begin
        point[0]   = data_in1;
        point[1]   = data_in2;
        point[2]   = data_in3;
        point[3]   = data_in4;
        cent[0][0] = centroid1_1;
        cent[0][1] = centroid1_2;
        cent[0][2] = centroid1_3;
        cent[0][3] = centroid1_4;
        cent[1][0] = centroid2_1;
        cent[1][1] = centroid2_2;
        cent[1][2] = centroid2_3;
        cent[1][3] = centroid2_4;
        cent[2][0] = centroid3_1;
        cent[2][1] = centroid3_2;
        cent[2][2] = centroid3_3;
        cent[2][3] = centroid3_4;
    end

    // ------------------------------------------------------------------------
    // Distance datapath: |p - c| per coordinate (larger minus smaller, so the
    // unsigned difference never wraps), squared, summed and saturated.
    // ------------------------------------------------------------------------
    logic [DIST_W-1:0] dist_next [3];

    genvar j, k;
    generate
        for (j = 0; j < 3; j++) begin : g_cent
            logic [SQ_W-1:0]  sq [4];
            logic [SUM_W-1:0] sum;

            for (k = 0; k < 4; k++) begin : g_coord
                logic [DATA_W-1:0] diff;
                assign diff  = (point[k] >= cent[j][k]) ? (point[k] - cent[j][k])
                                                         : (cent[j][k] - point[k]);
                assign sq[k] = SQ_W'(diff) * SQ_W'(diff);
            end

            assign sum = SUM_W'(sq[0]) + SUM_W'(sq[1]) + SUM_W'(sq[2]) + SUM_W'(sq[3]);

            // Any set bit above the output width means the distance does not
            // fit, so clamp to all-ones rather than truncate.
            assign dist_next[j] = (|sum[SUM_W-1:DIST_W]) ? {DIST_W{1'b1}}
                                                         : sum[DIST_W-1:0];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Nearest-centroid selection. Strict less-than keeps the earlier
    // (lower-index) centroid on a tie.
    // ------------------------------------------------------------------------
    logic [1:0]        nearest;
    logic [DIST_W-1:0] best;

    always_comb begin
        nearest = SEL_C1;
        best    = dist_next[0];
        if (dist_next[1] < best) begin
            nearest = SEL_C2;
            best    = dist_next[1];
        end
        if (dist_next[2] < best) begin
            nearest = SEL_C3;
        end
    end

    // ------------------------------------------------------------------------
    // Output registers: all four outputs update together on every edge.
    // Asynchronous reset drops any in-flight result immediately.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cluster_addr <= SEL_C1;
            dist_sum1    <= '0;
            dist_sum2    <= '0;
            dist_sum3    <= '0;
        end else begin
            cluster_addr <= nearest;
            dist_sum1    <= dist_next[0];
            dist_sum2    <= dist_next[1];
            dist_sum3    <= dist_next[2];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kmeans_clustering.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kmeans_clustering
//  Description : Directed self-checking bench for kmeans_clustering. Inputs
//                change on the falling edge; outputs are sampled 1 ns after
//                the rising edge (or mid-cycle for asynchronous reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kmeans_clustering;

    localparam int DATA_W = 16;
    localparam int DIST_W = 32;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] data_in1, data_in2, data_in3, data_in4;
    logic [DATA_W-1:0] centroid1_1, centroid1_2, centroid1_3, centroid1_4;
    logic [DATA_W-1:0] centroid2_1, centroid2_2, centroid2_3, centroid2_4;
    logic [DATA_W-1:0] centroid3_1, centroid3_2, centroid3_3, centroid3_4;
    logic [1:0]        cluster_addr;
    logic [DIST_W-1:0] dist_sum1, dist_sum2, dist_sum3;

    int checks   = 0;
    int failures = 0;

    kmeans_clustering #(.DATA_W(DATA_W), .DIST_W(DIST_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in1     (data_in1),
        .data_in2     (data_in2),
        .data_in3     (data_in3),
        .data_in4     (data_in4),
        .centroid1_1  (centroid1_1),
        .centroid1_2  (centroid1_2),
        .centroid1_3  (centroid1_3),
        .centroid1_4  (centroid1_4),
        .centroid2_1  (centroid2_1),
        .centroid2_2  (centroid2_2),
        .centroid2_3  (centroid2_3),
        .centroid2_4  (centroid2_4),
        .centroid3_1  (centroid3_1),
        .centroid3_2  (centroid3_2),
        .centroid3_3  (centroid3_3),
        .centroid3_4  (centroid3_4),
        .cluster_addr (cluster_addr),
        .dist_sum1    (dist_sum1),
        .dist_sum2    (dist_sum2),
        .dist_sum3    (dist_sum3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3,
                             input logic [1:0] ea);
        check({tag, ".dist1"}, 64'(dist_sum1), 64'(e1));
        check({tag, ".dist2"}, 64'(dist_sum2), 64'(e2));
        check({tag, ".dist3"}, 64'(dist_sum3), 64'(e3));
        check({tag, ".addr"},  64'(cluster_addr), 64'(ea));
    endtask

    task automatic set_point(input int a, input int b, input int c, input int d);
        data_in1 = 16'(a);
        data_in2 = 16'(b);
        data_in3 = 16'(c);
        data_in4 = 16'(d);
    endtask

    task automatic set_c1(input int a, input int b, input int c, input int d);
        centroid1_1 = 16'(a); centroid1_2 = 16'(b);
        centroid1_3 = 16'(c); centroid1_4 = 16'(d);
    endtask

    task automatic set_c2(input int a, input int b, input int c, input int d);
        centroid2_1 = 16'(a); centroid2_2 = 16'(b);
        centroid2_3 = 16'(c); centroid2_4 = 16'(d);
    endtask

    task automatic set_c3(input int a, input int b, input int c, input int d);
        centroid3_1 = 16'(a); centroid3_2 = 16'(b);
        centroid3_3 = 16'(c); centroid3_4 = 16'(d);
    endtask

    task automatic std_centroids();
        set_c1(4000, 3000, 1000,  500);
        set_c2(6000, 3200, 5000, 2000);
        set_c3(8000, 4000, 6000, 3000);
    endtask

    // Wait for the next rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        std_centroids();
        set_point(5100, 3500, 1400, 200);

        // Reset state before any clock edge.
        #2;
        check_all("reset_init", 0, 0, 0, 2'b00);

        // Release reset mid-cycle, point A.
        @(negedge clk);
        reset = 1'b1;
        step();
        check_all("pointA", 1710000, 17100000, 37660000, 2'b00);

        // Point B.
        @(negedge clk);
        set_point(7000, 3200, 4700, 1400);
        step();
        check_all("pointB", 23540000, 1450000, 5890000, 2'b01);

        // Point C.
        @(negedge clk);
        set_point(7600, 3000, 6600, 2100);
        step();
        check_all("pointC", 46880000, 5170000, 2330000, 2'b10);

        // Back-to-back: change input right after each edge, one per cycle.
        set_point(5100, 3500, 1400, 200);
        step();
        check("b2b.addr0", 64'(cluster_addr), 64'(2'b00));
        set_point(7000, 3200, 4700, 1400);
        step();
        check("b2b.addr1", 64'(cluster_addr), 64'(2'b01));
        check("b2b.dist2", 64'(dist_sum2), 64'd1450000);
        set_point(7600, 3000, 6600, 2100);
        step();
        check("b2b.addr2", 64'(cluster_addr), 64'(2'b10));
        check("b2b.dist3", 64'(dist_sum3), 64'd2330000);

        // Outputs hold between edges even when inputs change.
        set_point(5100, 3500, 1400, 200);
        @(negedge clk);
        #1;
        check("hold.addr", 64'(cluster_addr), 64'(2'b10));
        check("hold.dist3", 64'(dist_sum3), 64'd2330000);

        // Mid-stream asynchronous reset: outputs clear without a clock edge.
        reset = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 0, 2'b00);
        step();
        check_all("reset_held", 0, 0, 0, 2'b00);

        // Release reset: nothing until the next edge, then point A.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_release.dist1", 64'(dist_sum1), 64'd0);
        step();
        check_all("after_release", 1710000, 17100000, 37660000, 2'b00);

        // Saturation with a three-way tie.
        @(negedge clk);
        set_point(0, 0, 0, 0);
        set_c1(65535, 65535, 65535, 65535);
        set_c2(65535, 65535, 65535, 65535);
        set_c3(65535, 65535, 65535, 65535);
        step();
        check_all("saturate", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);

        // Just-fitting sum: single coordinate 65535 away, no saturation.
        @(negedge clk);
        set_c1(65535, 0, 0, 0);
        set_c2(0, 65535, 65535, 0);
        set_c3(1, 1, 1, 1);
        step();
        check_all("near_limit", 32'd4294836225, 32'hFFFF_FFFF, 32'd4, 2'b10);

        // Unsaturated tie between centroids 1 and 2 resolves to 1.
        @(negedge clk);
        set_point(5100, 3500, 1400, 200);
        set_c1(4000, 3000, 1000, 500);
        set_c2(4000, 3000, 1000, 500);
        set_c3(8000, 4000, 6000, 3000);
        step();
        check_all("tie12", 1710000, 1710000, 37660000, 2'b00);

        // Tie between centroids 2 and 3 resolves to 2.
        @(negedge clk);
        set_c2(5100, 3500, 1400, 200);
        set_c3(5100, 3500, 1400, 200);
        step();
        check_all("tie23", 1710000, 0, 0, 2'b01);

        // Point below centroid in every coordinate (reverse difference path).
        @(negedge clk);
        std_centroids();
        set_point(3000, 2000, 0, 0);
        step();
        // C1: 1000,1000,1000,500 -> 1e6+1e6+1e6+250000
        // C2: 3000,1200,5000,2000 -> 9e6+1.44e6+25e6+4e6
        // C3: 5000,2000,6000,3000 -> 25e6+4e6+36e6+9e6
        check_all("below", 3250000, 39440000, 74000000, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time bound so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
